// File: rtl/psum_norm.sv
// psum_norm: turns a row of absolute partial sums into per-column fractions abs[i]/sum.
// One restoring divider is shared across the columns. PSUM_NORM_ROUND_EN selects round-to-nearest.
module psum_norm #(
  parameter int col     = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int out_bw  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [col*bw_psum-1:0]  abs_in,
  input  logic [bw_psum+3:0]      sum_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [col*out_bw-1:0]   norm_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              state_dbg
);

  localparam int SW = bw_psum + 4;
  localparam int NW = bw_psum + out_bw + 4;
  localparam int RW = bw_psum + 5;
  localparam int CW = (col > 1) ? $clog2(col) : 1;
  localparam int KW = (out_bw > 1) ? $clog2(out_bw) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, DONE = 2'd2} state_t;

  state_t                   state, state_nxt;
  logic [col*bw_psum-1:0]   abs_r;
  logic [SW-1:0]            sum_r;
  logic [col*out_bw-1:0]    norm_r;
  logic [CW-1:0]            c_r;
  logic [KW-1:0]            k_r;
  logic [RW-1:0]            rem_r;
  logic [out_bw-1:0]        low_r;
  logic [out_bw-1:0]        q_r;
  logic                     sat_r;

  logic [bw_psum-1:0]       abs_cur;
  logic [NW-1:0]            num;
  logic [SW-1:0]            num_hi;
  logic                     sat_start;
  logic                     first_bit, last_bit, last_col;
  logic [RW-1:0]            cur_rem, shifted, rem_nxt;
  logic [out_bw-1:0]        cur_low, cur_q, q_nxt, col_val;
  logic                     cur_sat, ge;
  logic                     accept;

  // Handshakes: a transfer happens on any rising edge where valid && ready are both high;
  // valid never waits on ready, and in_ready/out_valid are pure functions of the state.
  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);
  assign norm_out  = norm_r;
  assign state_dbg = state;
  assign accept    = in_valid && in_ready;

  always_comb begin
    abs_cur = '0;
    for (int i = 0; i < col; i++)
      if (c_r == CW'(i)) abs_cur = abs_r[i*bw_psum +: bw_psum];
  end

`ifdef PSUM_NORM_ROUND_EN
  assign num = {4'b0, abs_cur, {out_bw{1'b0}}} + NW'(sum_r >> 1);
`else
  assign num = {4'b0, abs_cur, {out_bw{1'b0}}};
`endif

  // The integer part of num already reaching sum means the quotient needs more than out_bw bits.
  assign num_hi    = num[NW-1:out_bw];
  assign sat_start = (num_hi >= sum_r);
  assign first_bit = (k_r == '0);
  assign last_bit  = (k_r == KW'(out_bw-1));
  assign last_col  = (c_r == CW'(col-1));

  always_comb begin
    cur_rem = first_bit ? {1'b0, num_hi}   : rem_r;
    cur_low = first_bit ? num[out_bw-1:0]  : low_r;
    cur_q   = first_bit ? '0               : q_r;
    cur_sat = first_bit ? sat_start        : sat_r;
    shifted = {cur_rem[RW-2:0], cur_low[out_bw-1]};
    ge      = (shifted >= {1'b0, sum_r});
    rem_nxt = ge ? (shifted - {1'b0, sum_r}) : shifted;
    q_nxt   = {cur_q[out_bw-2:0], ge};
    col_val = cur_sat ? '1 : q_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (sum_in == '0) ? DONE : DIV;
      DIV:  if (last_bit && last_col) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      abs_r  <= '0;
      sum_r  <= '0;
      norm_r <= '0;
      c_r    <= '0;
      k_r    <= '0;
      rem_r  <= '0;
      low_r  <= '0;
      q_r    <= '0;
      sat_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          abs_r  <= abs_in;
          sum_r  <= sum_in;
          norm_r <= '0;
          c_r    <= '0;
          k_r    <= '0;
        end
        DIV: begin
          rem_r <= rem_nxt;
          low_r <= cur_low << 1;
          q_r   <= q_nxt;
          sat_r <= cur_sat;
          if (last_bit) begin
            for (int i = 0; i < col; i++)
              if (c_r == CW'(i)) norm_r[i*out_bw +: out_bw] <= col_val;
            k_r <= '0;
            c_r <= last_col ? '0 : c_r + 1'b1;
          end else begin
            k_r <= k_r + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_norm.sv
// Directed bench for psum_norm: latency, saturation, zero sum, rounding, backpressure, mid-row reset.
// Expected fractions are hand-computed; the rounding vector follows PSUM_NORM_ROUND_EN.
module tb_psum_norm;
  localparam int COL = 8;
  localparam int BWP = 20;
  localparam int OB  = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [COL*BWP-1:0]   abs_in;
  logic [BWP+3:0]       sum_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [COL*OB-1:0]    norm_out;
  logic                 out_valid;
  logic                 out_ready;
  logic [1:0]           state_dbg;

  int checks = 0;
  int passed = 0;
  logic [COL*OB-1:0] exp_q[$];

  psum_norm dut (
    .clk(clk), .reset(reset), .abs_in(abs_in), .sum_in(sum_in),
    .in_valid(in_valid), .in_ready(in_ready), .norm_out(norm_out),
    .out_valid(out_valid), .out_ready(out_ready), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_abs(input int i, input logic [BWP-1:0] v);
    abs_in[i*BWP +: BWP] = v;
  endtask

  task automatic send_row(input logic [BWP+3:0] s);
    sum_in   = s;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int start, output int lat);
    lat = start;
    while (out_valid !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%0b exp=0", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid); else passed++;
    checks++; if (norm_out !== '0) $display("FAIL reset_norm got=%h exp=0", norm_out); else passed++;
    checks++; if (state_dbg !== 2'd0) $display("FAIL reset_state got=%0d exp=0", state_dbg); else passed++;
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got=%0b exp=1", in_ready); else passed++;
  endtask

  task automatic test_uniform();
    logic [COL*OB-1:0] e;
    logic [COL*OB-1:0] got;
    int lat;
    for (int i = 0; i < COL; i++) begin set_abs(i, 20'd100); e[i*OB +: OB] = 8'd32; end
    exp_q.push_back(e);
    send_row(24'd800);
    checks++; if (state_dbg !== 2'd1) $display("FAIL uniform_state_div got=%0d exp=1", state_dbg); else passed++;
    wait_out(1, lat);
    checks++; if (lat != 65) $display("FAIL uniform_latency got=%0d exp=65", lat); else passed++;
    got = norm_out;
    e = exp_q.pop_front();
    checks++; if (got !== e) $display("FAIL uniform_norm got=%h exp=%h", got, e); else passed++;
    finish_out();
    checks++; if (in_ready !== 1'b1) $display("FAIL uniform_in_ready_after got=%0b exp=1", in_ready); else passed++;
  endtask

  task automatic test_single_col();
    logic [COL*OB-1:0] e;
    int lat;
    abs_in = '0;
    set_abs(3, 20'd500);
    e = '0; e[3*OB +: OB] = 8'd255;
    exp_q.push_back(e);
    send_row(24'd500);
    wait_out(1, lat);
    e = exp_q.pop_front();
    checks++; if (norm_out !== e) $display("FAIL single_sat got=%h exp=%h", norm_out, e); else passed++;
    finish_out();
    set_abs(3, 20'd250);
    e = '0; e[3*OB +: OB] = 8'd128;
    exp_q.push_back(e);
    send_row(24'd500);
    wait_out(1, lat);
    e = exp_q.pop_front();
    checks++; if (norm_out !== e) $display("FAIL single_half got=%h exp=%h", norm_out, e); else passed++;
    finish_out();
  endtask

  task automatic test_zero_sum();
    logic [COL*OB-1:0] e;
    int lat;
    for (int i = 0; i < COL; i++) set_abs(i, 20'h00777 + BWP'(i));
    send_row(24'd0);
    wait_out(1, lat);
    checks++; if (lat != 1) $display("FAIL zero_sum_latency got=%0d exp=1", lat); else passed++;
    checks++; if (norm_out !== '0) $display("FAIL zero_sum_norm got=%h exp=0", norm_out); else passed++;
    finish_out();
    abs_in = '0;
    set_abs(0, 20'd900);
    e = '0; e[7:0] = 8'd255;
    send_row(24'd300);
    wait_out(1, lat);
    checks++; if (lat != 65) $display("FAIL over_sum_latency got=%0d exp=65", lat); else passed++;
    checks++; if (norm_out !== e) $display("FAIL over_sum_norm got=%h exp=%h", norm_out, e); else passed++;
    finish_out();
  endtask

  task automatic test_rounding();
    logic [COL*OB-1:0] e;
    int lat;
    abs_in = '0;
    set_abs(0, 20'd2);
    e = '0;
`ifdef PSUM_NORM_ROUND_EN
    e[7:0] = 8'd171;
`else
    e[7:0] = 8'd170;
`endif
    send_row(24'd3);
    wait_out(1, lat);
    checks++; if (norm_out !== e) $display("FAIL rounding got=%h exp=%h", norm_out, e); else passed++;
    finish_out();
  endtask

  task automatic test_backpressure();
    logic [COL*OB-1:0] e;
    int lat;
    for (int i = 0; i < COL; i++) begin set_abs(i, BWP'(i*30)); e[i*OB +: OB] = OB'(i*30); end
    send_row(24'd256);
    wait_out(1, lat);
    checks++; if (lat != 65) $display("FAIL bp_latency got=%0d exp=65", lat); else passed++;
    for (int n = 0; n < 10; n++) begin
      in_valid = n[0];
      abs_in   = {COL{20'd7}};
      sum_in   = 24'd9;
      checks++; if (norm_out !== e) $display("FAIL bp_hold_norm cyc=%0d got=%h exp=%h", n, norm_out, e); else passed++;
      checks++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid cyc=%0d got=%0b exp=1", n, out_valid); else passed++;
      checks++; if (in_ready !== 1'b0) $display("FAIL bp_hold_in_ready cyc=%0d got=%0b exp=0", n, in_ready); else passed++;
      step();
    end
    in_valid = 1'b0;
    finish_out();
    checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready got=%0b exp=1", in_ready); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [COL*OB-1:0] e;
    int lat;
    for (int i = 0; i < COL; i++) begin set_abs(i, BWP'((i+1)*60)); e[i*OB +: OB] = OB'((i+1)*30); end
    exp_q.push_back(e);
    send_row(24'd512);
    checks++; if (norm_out !== '0) $display("FAIL b2b_cleared got=%h exp=0", norm_out); else passed++;
    for (int n = 1; n < 9; n++) step();
    checks++; if (norm_out !== 64'd30) $display("FAIL b2b_partial got=%h exp=%h", norm_out, 64'd30); else passed++;
    wait_out(9, lat);
    checks++; if (lat != 65) $display("FAIL b2b_latency got=%0d exp=65", lat); else passed++;
    e = exp_q.pop_front();
    checks++; if (norm_out !== e) $display("FAIL b2b_norm got=%h exp=%h", norm_out, e); else passed++;
    finish_out();
  endtask

  task automatic test_reset_mid_div();
    logic [COL*OB-1:0] e;
    int lat;
    for (int i = 0; i < COL; i++) begin set_abs(i, 20'd64); e[i*OB +: OB] = 8'd32; end
    send_row(24'd512);
    for (int n = 1; n < 30; n++) step();
    checks++; if (norm_out === '0) $display("FAIL mid_partial_present got=%h exp=nonzero", norm_out); else passed++;
    reset = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) $display("FAIL mid_reset_valid got=%0b exp=0", out_valid); else passed++;
    checks++; if (norm_out !== '0) $display("FAIL mid_reset_norm got=%h exp=0", norm_out); else passed++;
    checks++; if (state_dbg !== 2'd0) $display("FAIL mid_reset_state got=%0d exp=0", state_dbg); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL mid_reset_in_ready got=%0b exp=0", in_ready); else passed++;
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL mid_release_in_ready got=%0b exp=1", in_ready); else passed++;
    send_row(24'd512);
    wait_out(1, lat);
    checks++; if (lat != 65) $display("FAIL mid_next_latency got=%0d exp=65", lat); else passed++;
    checks++; if (norm_out !== e) $display("FAIL mid_next_norm got=%h exp=%h", norm_out, e); else passed++;
    finish_out();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    abs_in    = '0;
    sum_in    = '0;
    step();
    test_reset();
    test_uniform();
    test_single_col();
    test_zero_sum();
    test_rounding();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/psum_norm.md
# psum_norm

Consumer-side partner of the row adder. It takes the per-column absolute partial sums and their row total, and returns each column's share of the total as an unsigned fixed-point fraction: norm[i] = abs[i] / sum. It sits after the row adder at the end of the MAC array output path. It holds the row in registers and runs one sequential restoring divider across the columns, so a single divider is shared by all columns.

## Interface
Parameters:
- col, 8: number of columns per row
- bw, 8: MAC operand width
- bw_psum, 2*bw+4: width of one absolute partial sum
- out_bw, 8: fraction bits per normalized output

Ports:
- clk  input  1  clock; all logic on posedge
- reset  input  1  reset, synchronous and active-high
- abs_in  input  col*bw_psum  unsigned absolute psums; column i at [bw_psum*(i+1)-1 : bw_psum*i]
- sum_in  input  bw_psum+4  unsigned row total
- in_valid  input  1  abs_in and sum_in are valid
- in_ready  output  1  high only in IDLE and when reset is low
- norm_out  output  col*out_bw  normalized fractions; column i at [out_bw*(i+1)-1 : out_bw*i]
- out_valid  output  1  norm_out holds a complete result
- out_ready  input  1  downstream accepts norm_out

## Operation
- States: IDLE, DIV, DONE.
- IDLE:
  - On in_valid && in_ready, register abs_in and sum_in. Inputs may change after the accept cycle.
  - If sum_in == 0, go to DONE with norm_out = 0.
  - Otherwise go to DIV with column index c = 0 and bit counter k = 0.
- DIV:
  - Each cycle produces one quotient bit for column c, MSB first.
  - After out_bw cycles, write column c into norm_out[c], clear k and increment c.
  - After column col-1, go to DONE.
- DONE:
  - out_valid = 1; norm_out is held stable.
  - On out_ready, go to IDLE.
- Arithmetic:
  - num = abs[c] << out_bw, zero-extended to bw_psum+out_bw+4 bits.
  - Result = min(floor(num / sum), 2^out_bw - 1).
  - Saturation is decided at column start by checking num >= sum << out_bw. A saturating column still takes out_bw cycles and writes all ones.
  - Inconsistent inputs (abs[i] > sum) therefore saturate; they are not an error.
- Columns not yet computed hold 0 during DIV. norm_out is cleared on every accept.

## Timing
- Reset values: in_ready 0 while reset is high, otherwise 1 in IDLE. out_valid 0, norm_out 0, state IDLE, c = 0, k = 0.
- Accept at cycle T, nonzero sum: DIV runs for cycles T+1 through T+col*out_bw. out_valid rises at T+col*out_bw+1 (cycle 65 with defaults).
- Accept at cycle T, zero sum: out_valid at T+1.
- Output transfer happens in the cycle with out_valid && out_ready. in_ready returns high the next cycle.
- No input/output overlap: in_ready is low in DIV and DONE. Minimum issue interval is col*out_bw+2 cycles.
- out_ready low for any number of cycles: out_valid and norm_out hold unchanged.
- in_valid while not ready is ignored and not queued.
- Reset asserted in any state, including mid-DIV or DONE: the next cycle is IDLE with all outputs at reset values. The partial result is discarded.
- The divider remainder width is bw_psum+5 bits so the trial subtraction never overflows.

## Configuration
- PSUM_NORM_ROUND_EN:
  - Defined: round to nearest. num becomes (abs[c] << out_bw) + (sum >> 1), and the saturation check and division use this num.
  - Undefined: truncation toward zero.
  - Cycle counts are identical in both cases.

## Test plan
- Uniform split: abs all 100, sum 800 -> every norm = 32. out_valid exactly 65 cycles after accept.
- Single column:
  - abs[3] = 500, others 0, sum 500 -> norm[3] = 255 (saturated), others 0.
  - abs[3] = 250, sum 500 -> norm[3] = 128.
- Zero sum: sum 0, any abs -> all norm 0, out_valid one cycle after accept. Also, abs[0] = 900, sum 300 -> norm[0] = 255.
- Rounding: abs[0] = 2, sum 3 -> norm[0] = 170 with the macro undefined, 171 with PSUM_NORM_ROUND_EN.
- Backpressure then back-to-back rows:
  - Hold out_ready low 10 cycles -> norm_out stable, in_ready 0, in_valid pulses ignored.
  - Release out_ready -> in_ready 1 next cycle; the second row is accepted and correct.
- Reset mid-DIV at cycle 30 -> next cycle out_valid 0, norm_out 0. in_ready 1 once reset is low. The next row gives correct results.
